fan_adder_unit: RTL and testbench

- Reduction node of the sparse tensor-core forwarding adder network (FAN).
- Picks two of NUM_IN packed input lanes through per-slot select fields.
- Either adds the two picked lanes or forwards both unchanged (bypass) on one double-width registered output.
- One clock domain, one cycle of latency, synchronous active-high reset.

---
 rtl/fan_adder_unit.sv | 90 +++++++++
 tb/tb_fan_adder_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fan_adder_unit.sv
// FAN reduction node: selects two input lanes and either adds them or forwards both.
// Optional build macro FAN_ADDER_SIGNED_EN treats lanes as two's-complement for the add.
module fan_adder_unit #(
  parameter int unsigned DW_DATA = 8,
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned SEL_IN  = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 add_en,
  input  logic                                 bypass_en,
  input  logic [DW_DATA*NUM_IN-1:0]            in,
  input  logic [SEL_IN*$clog2(NUM_IN)-1:0]     sel,
  output logic [2*DW_DATA-1:0]                 out,
  output logic                                 out_valid
);

  localparam int unsigned SW = $clog2(NUM_IN);
  localparam int unsigned OW = 2 * DW_DATA;

  // Elaboration-time parameter legality
  generate
    if (SEL_IN != 2) begin : g_bad_sel_in
      $fatal(1, "fan_adder_unit: SEL_IN must be 2");
    end
    if ((NUM_IN < 2) || (NUM_IN > 16) || ((NUM_IN & (NUM_IN - 1)) != 0)) begin : g_bad_num_in
      $fatal(1, "fan_adder_unit: NUM_IN must be a power of two in 2..16");
    end
    if ((DW_DATA < 2) || (DW_DATA > 32)) begin : g_bad_dw
      $fatal(1, "fan_adder_unit: DW_DATA must be in 2..32");
    end
  endgenerate

  logic [DW_DATA-1:0] lane_c [NUM_IN];
  logic [DW_DATA-1:0] op_a_c;
  logic [DW_DATA-1:0] op_b_c;
  logic [DW_DATA:0]   sum_c;
  logic [OW-1:0]      add_res_c;
  logic [OW-1:0]      out_d;
  logic [OW-1:0]      out_q;
  logic               valid_q;

  generate
    for (genvar k = 0; k < NUM_IN; k++) begin : g_lane
      assign lane_c[k] = in[k*DW_DATA +: DW_DATA];
    end
  endgenerate

  // Operand muxes; both slots may pick the same lane
  always_comb begin
    op_a_c = lane_c[sel[0 +: SW]];
    op_b_c = lane_c[sel[SW +: SW]];
  end

`ifdef FAN_ADDER_SIGNED_EN
  always_comb begin
    sum_c     = {op_a_c[DW_DATA-1], op_a_c} + {op_b_c[DW_DATA-1], op_b_c};
    add_res_c = {{(DW_DATA-1){sum_c[DW_DATA]}}, sum_c};
  end
`else
  always_comb begin
    sum_c     = {1'b0, op_a_c} + {1'b0, op_b_c};
    add_res_c = OW'(sum_c);
  end
`endif

  // Add wins over bypass; with no enable the register holds
  always_comb begin
    out_d = out_q;
    if (add_en) begin
      out_d = add_res_c;
    end else if (bypass_en) begin
      out_d = {op_b_c, op_a_c};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= add_en | bypass_en;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_fan_adder_unit.sv
// Self-checking bench for fan_adder_unit: directed cases plus random ops vs an arithmetic model.
module tb_fan_adder_unit;

  localparam int unsigned DW = 8;
  localparam int unsigned NI = 4;
  localparam int unsigned SW = 2;

  logic              clk;
  logic              rst;
  logic              add_en;
  logic              bypass_en;
  logic [DW*NI-1:0]  in_v;
  logic [2*SW-1:0]   sel_v;
  logic [2*DW-1:0]   out_v;
  logic              out_valid_v;

  int total;
  int bad;

  longint exp_out;
  logic   exp_valid;

  fan_adder_unit #(.DW_DATA(DW), .NUM_IN(NI), .SEL_IN(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .add_en    (add_en),
    .bypass_en (bypass_en),
    .in        (in_v),
    .sel       (sel_v),
    .out       (out_v),
    .out_valid (out_valid_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  function automatic longint lane_val(input logic [DW*NI-1:0] v, input int idx);
    return longint'((v >> (idx * DW)) & ((1 << DW) - 1));
  endfunction

  function automatic longint as_signed(input longint x);
    if (x >= (longint'(1) << (DW - 1))) return x - (longint'(1) << DW);
    return x;
  endfunction

  // Applies one cycle of inputs, advances the model, checks one cycle later
  task automatic do_cycle(input string tag, input logic r, input logic ae, input logic be,
                          input logic [DW*NI-1:0] lanes, input int s0, input int s1);
    longint a;
    longint b;
    longint mask;
    rst       = r;
    add_en    = ae;
    bypass_en = be;
    in_v      = lanes;
    sel_v     = {2'(s1), 2'(s0)};
    mask      = (longint'(1) << (2 * DW)) - 1;
    a         = lane_val(lanes, s0);
    b         = lane_val(lanes, s1);
    if (r) begin
      exp_out   = 0;
      exp_valid = 1'b0;
    end else if (ae) begin
`ifdef FAN_ADDER_SIGNED_EN
      exp_out = (as_signed(a) + as_signed(b)) & mask;
`else
      exp_out = (a + b) & mask;
`endif
      exp_valid = 1'b1;
    end else if (be) begin
      exp_out   = b * (longint'(1) << DW) + a;
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check({tag, ".out"}, longint'(out_v), exp_out);
    check({tag, ".valid"}, longint'(out_valid_v), longint'(exp_valid));
  endtask

  logic [DW*NI-1:0] base;
  logic [DW*NI-1:0] ff_lanes;
  logic [DW*NI-1:0] rl;

  initial begin
    total     = 0;
    bad       = 0;
    exp_out   = 0;
    exp_valid = 1'b0;
    rst       = 1'b1;
    add_en    = 1'b0;
    bypass_en = 1'b0;
    in_v      = '0;
    sel_v     = '0;
    base      = {8'd1, 8'd2, 8'd3, 8'd4};
    ff_lanes  = {8'h00, 8'h00, 8'hFF, 8'hFF};

    @(negedge clk);
    do_cycle("reset0", 1'b1, 1'b1, 1'b0, base, 0, 1);
    do_cycle("reset1", 1'b1, 1'b1, 1'b0, base, 0, 1);
    do_cycle("idle", 1'b0, 1'b0, 1'b0, base, 0, 0);
    check("idle.hold_zero", longint'(out_v), 0);

    do_cycle("byp00", 1'b0, 1'b0, 1'b1, base, 0, 0);
    check("byp00.const", longint'(out_v), 16'h0404);
    do_cycle("byp13", 1'b0, 1'b0, 1'b1, base, 1, 3);
    check("byp13.const", longint'(out_v), 16'h0103);
    do_cycle("idle2", 1'b0, 1'b0, 1'b0, base, 2, 2);
    check("idle2.hold", longint'(out_v), 16'h0103);

    do_cycle("add00", 1'b0, 1'b1, 1'b0, base, 0, 0);
    check("add00.const", longint'(out_v), 16'd8);
    do_cycle("add13", 1'b0, 1'b1, 1'b0, base, 1, 3);
    check("add13.const", longint'(out_v), 16'd4);

    do_cycle("prio", 1'b0, 1'b1, 1'b1, ff_lanes, 0, 1);
`ifdef FAN_ADDER_SIGNED_EN
    check("prio.const", longint'(out_v), 16'hFFFE);
`else
    check("prio.const", longint'(out_v), 16'h01FE);
`endif

    // Back-to-back alternating add/bypass
    for (int i = 0; i < 8; i++) begin
      rl = $urandom;
      do_cycle("b2b", 1'b0, (i % 2) == 0, (i % 2) == 1, rl,
               int'($urandom_range(0, NI - 1)), int'($urandom_range(0, NI - 1)));
    end

    // Random mixed traffic including idle cycles and a mid-run reset
    for (int i = 0; i < 300; i++) begin
      rl = $urandom;
      do_cycle("rand", (i == 150), 1'($urandom), 1'($urandom), rl,
               int'($urandom_range(0, NI - 1)), int'($urandom_range(0, NI - 1)));
    end

    // Boundary lanes at all-ones and zero
    do_cycle("edge_ff", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 3, 2);
    do_cycle("edge_mix", 1'b0, 1'b1, 1'b0, 32'h80FF_7F00, 3, 1);
    do_cycle("edge_byp", 1'b0, 1'b0, 1'b1, 32'h80FF_7F00, 3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
